pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder.sv | 249 ++++++++++++++++++++++++
 tb/tb_pe_feeder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// ----------------------------------------------------------------------------
// pe_feeder
//
// Sequences one convolution pass into a PE array. It loads KERNEL_SIZE*CHANNELS
// weight beats, pulses an accumulator reset, streams cfg_ifm_beats ifm beats
// and then one psum beat. Each of the three streams passes through a one-entry
// output register, so there is one cycle of latency and no combinational path
// from an upstream valid to the matching downstream valid.
//
// Optional feature (compile-time macro):
//   PE_FEEDER_PSUM_EN  defined   : the psum beat is fetched from src_psum_*.
//                      undefined : src_psum_ready is tied low, and an all-zero
//                                  psum beat is issued in PSUM on its own.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   start               begins a pass; only looked at in IDLE
//   cfg_ifm_beats       ifm beat count, latched when start is accepted
//   busy, done          state != IDLE / one-cycle pulse in DONE
//   src_wht_*           upstream weight stream  (8*KERNEL_SIZE bits)
//   src_ifm_*           upstream ifm stream     (8*IFM_ROWS bits)
//   src_psum_*          upstream psum stream    (32*PE_COLS bits)
//   wht, wht_i_*        weight stream to the array
//   ifm, if_i_*         ifm stream to the array
//   psum, psum_i_*      psum stream to the array
//   reg_sft_en          weight shift enable, high on each weight handshake
//   acc_rst             high only in ARST
//   psum_acc_start      high on the first cycle of PSUM
//   mul_une, add_une    multiplier / adder disable flags
// ----------------------------------------------------------------------------
module pe_feeder #(
    parameter int CHANNELS    = 4,
    parameter int KERNEL_SIZE = 3,
    parameter int PE_COLS     = 8,
    parameter int IFM_ROWS    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                cfg_ifm_beats,
    output logic                      busy,
    output logic                      done,

    input  logic [8*KERNEL_SIZE-1:0]  src_wht_data,
    input  logic                      src_wht_valid,
    output logic                      src_wht_ready,
    input  logic [8*IFM_ROWS-1:0]     src_ifm_data,
    input  logic                      src_ifm_valid,
    output logic                      src_ifm_ready,
    input  logic [32*PE_COLS-1:0]     src_psum_data,
    input  logic                      src_psum_valid,
    output logic                      src_psum_ready,

    output logic [8*KERNEL_SIZE-1:0]  wht,
    output logic                      wht_i_valid,
    input  logic                      wht_i_ready,
    output logic [8*IFM_ROWS-1:0]     ifm,
    output logic                      if_i_valid,
    input  logic                      if_i_ready,
    output logic [32*PE_COLS-1:0]     psum,
    output logic                      psum_i_valid,
    input  logic                      psum_i_ready,

    output logic                      reg_sft_en,
    output logic                      acc_rst,
    output logic                      psum_acc_start,
    output logic                      mul_une,
    output logic                      add_une
);

    localparam int WHT_BEATS = KERNEL_SIZE * CHANNELS;
    localparam int WCW       = $clog2(WHT_BEATS + 1);

    typedef enum logic [2:0] {IDLE, WLOAD, ARST, IFM, PSUM, DONE} state_t;

    state_t               state;
    logic [WCW-1:0]       wht_acc;      // beats accepted from src_wht
    logic [WCW-1:0]       wht_cnt;      // beats handed to the array
    logic [7:0]           ifm_target;
    logic [7:0]           ifm_acc;
    logic [7:0]           ifm_cnt;
    logic                 psum_fetched; // the single psum beat has been loaded

    logic                 wht_load, wht_drain;
    logic                 ifm_load, if_drain;
    logic                 psum_take_ok, psum_load, psum_drain;
    logic [32*PE_COLS-1:0] psum_src;

    // ------------------------------------------------------------------
    // Handshakes. The source side is gated by the accepted-beat count so a
    // pass never pulls more beats than it will hand downstream, and by rst
    // so an abandoned pass does not complete one last upstream transfer.
    // ------------------------------------------------------------------
    assign src_wht_ready = !rst && (state == WLOAD) && (!wht_i_valid || wht_i_ready)
                           && (wht_acc < WCW'(WHT_BEATS));
    assign wht_load      = src_wht_valid && src_wht_ready;
    assign wht_drain     = wht_i_valid && wht_i_ready;

    assign src_ifm_ready = !rst && (state == IFM) && (!if_i_valid || if_i_ready)
                           && (ifm_acc < ifm_target);
    assign ifm_load      = src_ifm_valid && src_ifm_ready;
    assign if_drain      = if_i_valid && if_i_ready;

    assign psum_take_ok  = !rst && (state == PSUM) && (!psum_i_valid || psum_i_ready)
                           && !psum_fetched;
    assign psum_drain    = psum_i_valid && psum_i_ready;

`ifdef PE_FEEDER_PSUM_EN
    assign src_psum_ready = psum_take_ok;
    assign psum_load      = psum_take_ok && src_psum_valid;
    assign psum_src       = src_psum_data;
`else
    // The beat is synthesised locally; the upstream psum port is idle.
    logic psum_unused;
    assign psum_unused    = ^{src_psum_data, src_psum_valid};
    assign src_psum_ready = 1'b0;
    assign psum_load      = psum_take_ok;
    assign psum_src       = '0;
`endif

    assign busy       = (state != IDLE);
    assign reg_sft_en = wht_drain;

    // ------------------------------------------------------------------
    // One-entry output registers. A load takes priority over a drain, so a
    // simultaneous load and drain keeps valid high with the new data.
    // NOTE: data registers are reset along with valid so the array never
    // sees stale beats from an abandoned pass; they are flops, not a RAM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wht         <= '0;
            wht_i_valid <= 1'b0;
        end else if (wht_load) begin
            wht         <= src_wht_data;
            wht_i_valid <= 1'b1;
        end else if (wht_drain) begin
            wht_i_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifm        <= '0;
            if_i_valid <= 1'b0;
        end else if (ifm_load) begin
            ifm        <= src_ifm_data;
            if_i_valid <= 1'b1;
        end else if (if_drain) begin
            if_i_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psum         <= '0;
            psum_i_valid <= 1'b0;
        end else if (psum_load) begin
            psum         <= psum_src;
            psum_i_valid <= 1'b1;
        end else if (psum_drain) begin
            psum_i_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Beat counters, cleared when a pass is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wht_acc      <= '0;
            wht_cnt      <= '0;
            ifm_target   <= '0;
            ifm_acc      <= '0;
            ifm_cnt      <= '0;
            psum_fetched <= 1'b0;
        end else if (state == IDLE && start) begin
            wht_acc      <= '0;
            wht_cnt      <= '0;
            ifm_target   <= cfg_ifm_beats;
            ifm_acc      <= '0;
            ifm_cnt      <= '0;
            psum_fetched <= 1'b0;
        end else begin
            if (wht_load)  wht_acc      <= wht_acc + WCW'(1);
            if (wht_drain) wht_cnt      <= wht_cnt + WCW'(1);
            if (ifm_load)  ifm_acc      <= ifm_acc + 8'd1;
            if (if_drain)  ifm_cnt      <= ifm_cnt + 8'd1;
            if (psum_load) psum_fetched <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pass sequencer. Control outputs are registered and updated on the
    // transition into the state that owns them.
    // NOTE: every state and output flop here uses <= so all of them see the
    // same pre-edge values; a blocking write would leak into later reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            done           <= 1'b0;
            acc_rst        <= 1'b0;
            psum_acc_start <= 1'b0;
            mul_une        <= 1'b1;
            add_une        <= 1'b1;
        end else begin
            psum_acc_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= WLOAD;
                end
                WLOAD: begin
                    if (wht_drain && wht_cnt == WCW'(WHT_BEATS - 1)) begin
                        state   <= ARST;
                        acc_rst <= 1'b1;
                    end
                end
                ARST: begin
                    state   <= IFM;
                    acc_rst <= 1'b0;
                    mul_une <= 1'b0;
                end
                IFM: begin
                    // A zero-beat pass spends exactly one cycle here.
                    if (ifm_target == 8'd0 || (if_drain && (ifm_cnt + 8'd1) == ifm_target)) begin
                        state          <= PSUM;
                        add_une        <= 1'b0;
                        psum_acc_start <= 1'b1;
                    end
                end
                PSUM: begin
                    if (psum_drain) begin
                        state   <= DONE;
                        mul_une <= 1'b1;
                        add_une <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// ----------------------------------------------------------------------------
// tb_pe_feeder
//
// Randomised bench for pe_feeder. Sources and the array side are driven with
// $urandom valid/ready patterns; a queue-based model of the pass (phase, beat
// totals, one pending beat per stream) predicts every output each cycle.
// Directed passes add literal expectations for cycle counts and pulses.
// ----------------------------------------------------------------------------
module tb_pe_feeder;

    localparam int K  = 3;
    localparam int C  = 4;
    localparam int P  = 8;
    localparam int R  = 10;
    localparam int WB = K * C;
    localparam int WW = 8 * K;
    localparam int IW = 8 * R;
    localparam int PW = 32 * P;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    cfg_ifm_beats;
    logic          busy, done;
    logic [WW-1:0] src_wht_data;
    logic          src_wht_valid, src_wht_ready;
    logic [IW-1:0] src_ifm_data;
    logic          src_ifm_valid, src_ifm_ready;
    logic [PW-1:0] src_psum_data;
    logic          src_psum_valid, src_psum_ready;
    logic [WW-1:0] wht;
    logic          wht_i_valid, wht_i_ready;
    logic [IW-1:0] ifm;
    logic          if_i_valid, if_i_ready;
    logic [PW-1:0] psum;
    logic          psum_i_valid, psum_i_ready;
    logic          reg_sft_en, acc_rst, psum_acc_start, mul_une, add_une;

    always #5 clk = ~clk;

    pe_feeder #(
        .CHANNELS(C), .KERNEL_SIZE(K), .PE_COLS(P), .IFM_ROWS(R)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_ifm_beats(cfg_ifm_beats),
        .busy(busy), .done(done),
        .src_wht_data(src_wht_data), .src_wht_valid(src_wht_valid), .src_wht_ready(src_wht_ready),
        .src_ifm_data(src_ifm_data), .src_ifm_valid(src_ifm_valid), .src_ifm_ready(src_ifm_ready),
        .src_psum_data(src_psum_data), .src_psum_valid(src_psum_valid), .src_psum_ready(src_psum_ready),
        .wht(wht), .wht_i_valid(wht_i_valid), .wht_i_ready(wht_i_ready),
        .ifm(ifm), .if_i_valid(if_i_valid), .if_i_ready(if_i_ready),
        .psum(psum), .psum_i_valid(psum_i_valid), .psum_i_ready(psum_i_ready),
        .reg_sft_en(reg_sft_en), .acc_rst(acc_rst), .psum_acc_start(psum_acc_start),
        .mul_une(mul_une), .add_une(add_une)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stimulus knobs (percent chance of valid / ready per cycle).
    int src_pct = 100;
    int dn_pct  = 100;

    // Behavioural model of a pass.
    typedef enum {M_IDLE, M_WLOAD, M_ARST, M_IFM, M_PSUM, M_DONE} mph_t;
    mph_t          ph = M_IDLE;
    bit            pfirst = 1'b0;
    logic [WW-1:0] wq[$];
    logic [IW-1:0] iq[$];
    logic [PW-1:0] pq[$];
    int w_acc = 0, w_out = 0, i_acc = 0, i_out = 0, p_acc = 0, p_out = 0, i_target = 0;

    // Source bookkeeping.
    int w_idx = 0;
    bit w_hs = 1'b0, i_hs = 1'b0, p_hs = 1'b0;

    // Per-pass statistics for literal expectations.
    int st_busy, st_sft, st_acc, st_ifhs, st_done, st_ifv, st_pas_idx, st_wht;

    task automatic clear_stats();
        st_busy = 0; st_sft = 0; st_acc = 0; st_ifhs = 0;
        st_done = 0; st_ifv = 0; st_pas_idx = -1; st_wht = 0;
    endtask

    task automatic drive_inputs();
        if (ph == M_IDLE) begin
            src_wht_valid  = 1'b0;
            src_ifm_valid  = 1'b0;
            src_psum_valid = 1'b0;
            w_idx          = 0;
        end else begin
            // A source holds its beat until it is taken.
            if (!src_wht_valid || w_hs) begin
                src_wht_valid     = ($urandom_range(0, 99) < src_pct);
                src_wht_data      = WW'({$urandom, $urandom});
                src_wht_data[7:0] = 8'(w_idx);
            end
            if (!src_ifm_valid || i_hs) begin
                src_ifm_valid = ($urandom_range(0, 99) < src_pct);
                src_ifm_data  = IW'({$urandom, $urandom, $urandom});
            end
            if (!src_psum_valid || p_hs) begin
                src_psum_valid = ($urandom_range(0, 99) < src_pct);
                for (int j = 0; j < P; j++) src_psum_data[32*j +: 32] = $urandom;
            end
        end
        wht_i_ready  = ($urandom_range(0, 99) < dn_pct);
        if_i_ready   = ($urandom_range(0, 99) < dn_pct);
        psum_i_ready = ($urandom_range(0, 99) < dn_pct);
    endtask

    task automatic check_cycle();
        bit ew, ei, ep, ep_take, wl, il, pl, wd, id, pd;
        logic [PW-1:0] pdat;
        ew = !rst && ph == M_WLOAD && (wq.size() == 0 || wht_i_ready) && w_acc < WB;
        ei = !rst && ph == M_IFM && (iq.size() == 0 || if_i_ready) && i_acc < i_target;
        ep_take = !rst && ph == M_PSUM && (pq.size() == 0 || psum_i_ready) && p_acc < 1;
`ifdef PE_FEEDER_PSUM_EN
        ep   = ep_take;
        pl   = ep_take && src_psum_valid;
        pdat = src_psum_data;
`else
        ep   = 1'b0;
        pl   = ep_take;
        pdat = '0;
`endif
        wd = wq.size() != 0 && wht_i_ready;
        id = iq.size() != 0 && if_i_ready;
        pd = pq.size() != 0 && psum_i_ready;

        check("busy", busy, ph != M_IDLE);
        check("done", done, ph == M_DONE);
        check("acc_rst", acc_rst, ph == M_ARST);
        check("psum_acc_start", psum_acc_start, pfirst);
        check("mul_une", mul_une, !(ph == M_IFM || ph == M_PSUM));
        check("add_une", add_une, ph != M_PSUM);
        check("reg_sft_en", reg_sft_en, wd);
        check("wht_i_valid", wht_i_valid, wq.size() != 0);
        check("if_i_valid", if_i_valid, iq.size() != 0);
        check("psum_i_valid", psum_i_valid, pq.size() != 0);
        check("src_wht_ready", src_wht_ready, ew);
        check("src_ifm_ready", src_ifm_ready, ei);
        check("src_psum_ready", src_psum_ready, ep);
        if (wq.size() != 0) check("wht_data", wht, wq[0]);
        if (iq.size() != 0) check("ifm_data", ifm, iq[0]);
        if (pq.size() != 0) check("psum_data", psum, pq[0]);
        if (wd) check("wht_order", wht[7:0], 8'(w_out));

        if (busy) st_busy++;
        if (reg_sft_en) st_sft++;
        if (acc_rst) st_acc++;
        if (if_i_valid && if_i_ready) st_ifhs++;
        if (wht_i_valid && wht_i_ready) st_wht++;
        if (done) st_done++;
        if (if_i_valid) st_ifv++;
        if (psum_acc_start) st_pas_idx = st_busy - 1;

        w_hs = src_wht_valid && src_wht_ready;
        i_hs = src_ifm_valid && src_ifm_ready;
        p_hs = src_psum_valid && src_psum_ready;
        if (w_hs) w_idx++;

        if (rst) begin
            ph = M_IDLE; pfirst = 1'b0;
            wq.delete(); iq.delete(); pq.delete();
            w_acc = 0; w_out = 0; i_acc = 0; i_out = 0; p_acc = 0; p_out = 0;
        end else begin
            wl = src_wht_valid && ew;
            il = src_ifm_valid && ei;
            if (wd) void'(wq.pop_front());
            if (wl) wq.push_back(src_wht_data);
            if (id) void'(iq.pop_front());
            if (il) iq.push_back(src_ifm_data);
            if (pd) void'(pq.pop_front());
            if (pl) pq.push_back(pdat);
            w_acc += int'(wl); w_out += int'(wd);
            i_acc += int'(il); i_out += int'(id);
            p_acc += int'(pl); p_out += int'(pd);
            pfirst = 1'b0;
            case (ph)
                M_IDLE: if (start) begin
                    ph = M_WLOAD;
                    w_acc = 0; w_out = 0; i_acc = 0; i_out = 0; p_acc = 0; p_out = 0;
                    i_target = int'(cfg_ifm_beats);
                end
                M_WLOAD: if (w_out == WB) ph = M_ARST;
                M_ARST:  ph = M_IFM;
                M_IFM:   if (i_out == i_target) begin ph = M_PSUM; pfirst = 1'b1; end
                M_PSUM:  if (p_out == 1) ph = M_DONE;
                M_DONE:  ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit
    // before the rising edge that commits them.
    initial begin
        forever begin
            @(negedge clk);
            drive_inputs();
            #4;
            check_cycle();
        end
    end

    task automatic run_pass(input logic [7:0] beats, input bit poke);
        int budget;
        cfg_ifm_beats = beats;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_ifm_beats = 8'($urandom);   // must not matter after the latch
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        budget = 0;
        while (st_done == 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("pass_timeout", budget < 3000, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int budget;
        int nb;
        rst = 1'b1; start = 1'b0; cfg_ifm_beats = 8'd0;
        src_wht_valid = 1'b0; src_ifm_valid = 1'b0; src_psum_valid = 1'b0;
        src_wht_data = '0; src_ifm_data = '0; src_psum_data = '0;
        wht_i_ready = 1'b0; if_i_ready = 1'b0; psum_i_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wht", wht, '0);
        check("rst_ifm", ifm, '0);
        check("rst_psum", psum, '0);
        check("rst_mul_une", mul_une, 1'b1);
        check("rst_add_une", add_une, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Everything ready, 5 ifm beats: WLOAD 13 + ARST 1 + IFM 6 + PSUM 2
        // + DONE 1 = 23 busy cycles; PSUM starts at busy cycle 20.
        src_pct = 100; dn_pct = 100;
        clear_stats();
        run_pass(8'd5, 1'b0);
        check("a_busy_cycles", 32'(st_busy), 32'd23);
        check("a_sft_beats", 32'(st_sft), 32'd12);
        check("a_acc_rst", 32'(st_acc), 32'd1);
        check("a_ifm_beats", 32'(st_ifhs), 32'd5);
        check("a_done", 32'(st_done), 32'd1);
        check("a_pas_idx", 32'(st_pas_idx), 32'd20);

        // Stalls on both sides, plus a start pulse while in WLOAD.
        src_pct = 70; dn_pct = 50;
        clear_stats();
        run_pass(8'd5, 1'b1);
        check("b_wht_beats", 32'(st_wht), 32'd12);
        check("b_ifm_beats", 32'(st_ifhs), 32'd5);
        check("b_done", 32'(st_done), 32'd1);

        // Zero ifm beats: 13 + 1 + 1 + 2 + 1 = 18 busy cycles, PSUM at 15.
        src_pct = 100; dn_pct = 100;
        clear_stats();
        run_pass(8'd0, 1'b0);
        check("c_busy_cycles", 32'(st_busy), 32'd18);
        check("c_if_valid", 32'(st_ifv), 32'd0);
        check("c_pas_idx", 32'(st_pas_idx), 32'd15);
        check("c_done", 32'(st_done), 32'd1);

        // Reset in IFM after 3 beats, then a fresh pass.
        clear_stats();
        cfg_ifm_beats = 8'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (st_ifhs < 3 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("d_reach_ifm", budget < 200, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("d_wht_valid", wht_i_valid, 1'b0);
        check("d_if_valid", if_i_valid, 1'b0);
        check("d_psum_valid", psum_i_valid, 1'b0);
        check("d_busy", busy, 1'b0);
        check("d_done_none", 32'(st_done), 32'd0);
        @(negedge clk);
        clear_stats();
        run_pass(8'd4, 1'b0);
        check("d_wht_beats", 32'(st_wht), 32'd12);
        check("d_sft_beats", 32'(st_sft), 32'd12);
        check("d_done", 32'(st_done), 32'd1);

        // Random passes.
        for (int n = 0; n < 8; n++) begin
            src_pct = $urandom_range(30, 100);
            dn_pct  = $urandom_range(30, 100);
            nb      = $urandom_range(0, 7);
            clear_stats();
            run_pass(8'(nb), 1'($urandom_range(0, 1)));
            check("r_ifm_beats", 32'(st_ifhs), 32'(nb));
            check("r_wht_beats", 32'(st_wht), 32'd12);
            check("r_done", 32'(st_done), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
